// File: rtl/jogo_pkg.sv
// Shared definitions for the game control unit: state codes, default timeout
// and the Moore output decode used by the controller.
package jogo_pkg;

    localparam int unsigned TIMEOUT_CICLOS_PADRAO = 5000;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    typedef struct packed {
        logic zera_c;
        logic conta_c;
        logic registra;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } saidas_t;

    function automatic saidas_t decodifica(input estado_t estado);
        saidas_t s;
        s = '0;
        case (estado)
            PREPARA:     s.zera_c   = 1'b1;
            REGISTRA:    s.registra = 1'b1;
            PROXIMO:     s.conta_c  = 1'b1;
            FIM_ACERTO: begin
                s.pronto  = 1'b1;
                s.acertou = 1'b1;
            end
            FIM_ERRO: begin
                s.pronto = 1'b1;
                s.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                s.pronto  = 1'b1;
                s.errou   = 1'b1;
                s.timeout = 1'b1;
            end
            default:     s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse when sinal goes from 0 to 1.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinal_q <= 1'b0;
        end else begin
            sinal_q <= sinal;
        end
    end

    assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/unidade_controle_jogadas.sv
// Moore control unit for the play sequence: waits for button presses, checks
// each play against the datapath and ends on success, error or timeout.
module unidade_controle_jogadas
    import jogo_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim,
    output logic       zera_c,
    output logic       conta_c,
    output logic       registra,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int unsigned TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TW-1:0] TC_MAX = TW'(TIMEOUT_CICLOS - 1);

    estado_t       estado;
    estado_t       prox;
    logic          pulso_jogada;
    logic [TW-1:0] tc;
    saidas_t       s;

    edge_detector u_edge_jogada (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (pulso_jogada)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox;
        end
    end

    // Counter only runs while waiting; leaving ESPERA (via PREPARA/PROXIMO) restarts it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tc <= '0;
        end else if (estado == ESPERA) begin
            tc <= tc + 1'b1;
        end else begin
            tc <= '0;
        end
    end

    always_comb begin
        prox = estado;
        unique case (estado)
            INICIAL:  if (iniciar) prox = PREPARA;
            PREPARA:  prox = ESPERA;
            ESPERA: begin
                if (pulso_jogada) begin
                    prox = REGISTRA;
                end else if (tc == TC_MAX) begin
                    prox = FIM_TIMEOUT;
                end
            end
            REGISTRA: prox = COMPARA;
            COMPARA: begin
                if (!igual) begin
                    prox = FIM_ERRO;
                end else if (fim) begin
                    prox = FIM_ACERTO;
                end else begin
                    prox = PROXIMO;
                end
            end
            PROXIMO:  prox = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar) prox = PREPARA;
            default:  prox = INICIAL;
        endcase
    end

    always_comb begin
        s         = decodifica(estado);
        zera_c    = s.zera_c;
        conta_c   = s.conta_c;
        registra  = s.registra;
        pronto    = s.pronto;
        acertou   = s.acertou;
        errou     = s.errou;
        timeout   = s.timeout;
        db_estado = estado;
    end

endmodule

// File: tb/tb_unidade_controle_jogadas.sv
// Bench for unidade_controle_jogadas: directed start/reset checks, then
// randomized games scored against a game-level timeline model.
module tb_unidade_controle_jogadas;

    localparam int unsigned T = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fim = 1'b0;
    logic       zera_c, conta_c, registra, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [10:0] outs;

    int unsigned cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;

    typedef struct {
        int unsigned fin_cyc;
        int unsigned end_cyc;
        logic [3:0]  code;
        logic        acer, err, tmo;
        int unsigned nreg, ncon;
    } exp_t;
    exp_t sb[$];

    unidade_controle_jogadas #(.TIMEOUT_CICLOS(T)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fim(fim), .zera_c(zera_c), .conta_c(conta_c),
        .registra(registra), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    assign outs = {zera_c, conta_c, registra, pronto, acertou, errou, timeout, db_estado};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Expected outs vector: {zera, conta, registra, pronto, acertou, errou, timeout, db}
    task automatic chk_outs(input string name, input logic [10:0] exp);
        @(negedge clock);
        chk(name, 32'(outs), 32'(exp));
    endtask

    // One game: plan the whole input timeline from the rules, push the outcome, replay it.
    task automatic run_game(input int unsigned kind);
        logic ini_w[512], jog_w[512], igu_w[512], fim_w[512];
        int unsigned dl[16];
        int unsigned last, e, f, c, h, hmax, hd, len, nreg, ncon, k0;
        exp_t x;
        last = (kind == 0) ? 15 : $urandom_range(0, 15);
        for (int unsigned i = 0; i < 16; i++)
            dl[i] = ($urandom_range(0, 3) == 0) ? T - 1 : $urandom_range(1, T - 1);
        if (kind == 2) dl[last] = T + $urandom_range(0, 3);
        for (int unsigned i = 0; i < 512; i++) begin
            ini_w[i] = ($urandom_range(0, 3) == 0);
            jog_w[i] = 1'b0;
            igu_w[i] = 1'($urandom_range(0, 1));
            fim_w[i] = 1'($urandom_range(0, 1));
        end
        ini_w[0] = 1'b1;
        e = 2; f = 0; nreg = 0; ncon = 0;
        for (int unsigned i = 0; i <= last; i++) begin
            if (dl[i] >= T) begin
                f = e + T;
                break;
            end
            hmax = (i == last) ? 20 : dl[i+1] + 3;
            h = $urandom_range(1, hmax);
            for (int unsigned j = 0; j < h; j++) jog_w[e + dl[i] + j] = 1'b1;
            c = e + dl[i] + 2;
            nreg++;
            if (i == last) begin
                igu_w[c] = (kind == 0);
                if (kind == 0) fim_w[c] = 1'b1;
                f = c + 1;
            end else begin
                igu_w[c] = 1'b1;
                fim_w[c] = 1'b0;
                ncon++;
                e = c + 2;
            end
        end
        hd = $urandom_range(2, 5);
        for (int unsigned i = f; i < f + hd; i++) ini_w[i] = 1'b0;
        len = f + hd;

        next_cycle();
        k0 = cyc;
        x.fin_cyc = k0 + f;
        x.end_cyc = k0 + len;
        x.code = (kind == 0) ? 4'hA : (kind == 1) ? 4'hE : 4'hD;
        x.acer = (kind == 0);
        x.err  = (kind != 0);
        x.tmo  = (kind == 2);
        x.nreg = nreg;
        x.ncon = ncon;
        sb.push_back(x);
        for (int unsigned t = 0; t < len; t++) begin
            if (t != 0) next_cycle();
            iniciar = ini_w[t];
            jogada  = jog_w[t];
            igual   = igu_w[t];
            fim     = fim_w[t];
        end
    endtask

    // Monitor: count control pulses per game, score each final state and its exit.
    initial begin
        int unsigned zc = 0, cc = 0, rc = 0;
        bit onehot_bad = 0, pend = 0;
        logic pronto_q = 1'b0;
        exp_t cur;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                zc += 32'(zera_c); cc += 32'(conta_c); rc += 32'(registra);
                if ((32'(zera_c) + 32'(conta_c) + 32'(registra)) > 1) onehot_bad = 1;
                if (pronto && !pronto_q) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_final", 32'(db_estado), 32'hF);
                    end else begin
                        cur = sb.pop_front();
                        chk("final_cycle", cyc, cur.fin_cyc);
                        chk("final_code", 32'(db_estado), 32'(cur.code));
                        chk("final_flags", {pronto, acertou, errou, timeout},
                            {1'b1, cur.acer, cur.err, cur.tmo});
                        chk("final_ctrl", {zera_c, conta_c, registra}, 3'b000);
                        chk("zera_count", zc, 1);
                        chk("registra_count", rc, cur.nreg);
                        chk("conta_count", cc, cur.ncon);
                        chk("ctrl_onehot", 32'(onehot_bad), 0);
                        pend = 1;
                    end
                    zc = 0; cc = 0; rc = 0; onehot_bad = 0;
                end
                if (!pronto && pronto_q && pend) begin
                    chk("restart_cycle", cyc, cur.end_cyc + 1);
                    chk("restart_state", 32'(db_estado), 32'h1);
                    pend = 0;
                end
                pronto_q = pronto;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with busy inputs
        iniciar = 1'b1; jogada = 1'b1; igual = 1'b1; fim = 1'b1;
        repeat (3) next_cycle();
        chk_outs("reset_held", 11'h000);
        next_cycle();
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fim = 1'b0;
        chk_outs("idle_after_reset", 11'h000);
        next_cycle(); iniciar = 1'b1;
        chk_outs("start_inicial", 11'h000);
        next_cycle(); iniciar = 1'b0;
        chk_outs("start_prepara", {7'b1000000, 4'h1});
        next_cycle();
        chk_outs("start_espera", {7'b0000000, 4'h2});
        next_cycle(); jogada = 1'b1;
        chk_outs("press_espera", {7'b0000000, 4'h2});
        next_cycle(); igual = 1'b0;
        chk_outs("registra_state", {7'b0010000, 4'h4});
        next_cycle(); igual = 1'b1; fim = 1'b0;
        chk_outs("compara_state", {7'b0000000, 4'h5});
        next_cycle();
        chk_outs("proximo_state", {7'b0100000, 4'h6});
        next_cycle();
        chk_outs("held_espera1", {7'b0000000, 4'h2});
        next_cycle();
        chk_outs("held_espera2", {7'b0000000, 4'h2});
        next_cycle(); jogada = 1'b0;
        next_cycle(); jogada = 1'b1;
        next_cycle();
        chk_outs("second_registra", {7'b0010000, 4'h4});
        next_cycle(); igual = 1'b1; fim = 1'b1;
        chk_outs("second_compara", {7'b0000000, 4'h5});
        #2 reset = 1'b0;
        #1 chk("async_reset_outs", 32'(outs), 0);
        next_cycle(); reset = 1'b1; iniciar = 1'b0; jogada = 1'b0;
        chk_outs("abandoned_game", 11'h000);
        next_cycle();
        chk_outs("still_inicial", 11'h000);

        mon_en = 1;
        for (int unsigned g = 0; g < 30; g++)
            run_game((g < 3) ? g : $urandom_range(0, 2));
        next_cycle(); iniciar = 1'b1;
        next_cycle(); iniciar = 1'b0;
        repeat (3) next_cycle();
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
